// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl: next-PC source selection and PC write sequencing.
// Resolves branches/jumps and runs the exception entry sequence.
module pc_source_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_gt,
    input  logic       ovf_exc,
    input  logic       div0_exc,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       epc_write,
    output logic       mem_read,
    output logic [1:0] exc_code,
    output logic       busy,
    output logic       done
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

    localparam logic [2:0] SRC_PC4 = 3'b000;
    localparam logic [2:0] SRC_BR  = 3'b001;
    localparam logic [2:0] SRC_J   = 3'b010;
    localparam logic [2:0] SRC_JR  = 3'b011;
    localparam logic [2:0] SRC_VEC = 3'b100;

    localparam logic [1:0] EXC_INV  = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_DIV0 = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESOLVE,
        S_WRITE,
        S_EXC_EPC,
        S_EXC_WAIT,
        S_EXC_LOAD,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [5:0]    op_q;
    logic [5:0]    funct_q;
    logic [CW-1:0] wait_cnt;

    logic          valid_op;
    logic          exc_d;
    logic [1:0]    code_d;
    logic [2:0]    tgt_d;
    logic [2:0]    sel_d;
    logic          taken_d;

    logic [2:0]    src_d;
    logic          pc_write_d;
    logic          epc_write_d;
    logic          mem_read_d;
    logic          busy_d;
    logic          done_d;

    // Opcode legality check against the supported instruction set
    always_comb begin
        valid_op = op_q inside {
            6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
            6'h06, 6'h07, 6'h08, 6'h09, 6'h0F, 6'h20,
            6'h21, 6'h23, 6'h28, 6'h29, 6'h2B
        };
    end

    // Exception detection: invalid opcode beats overflow beats div-by-zero
    always_comb begin
        exc_d  = 1'b0;
        code_d = EXC_INV;
        unique case (1'b1)
            !valid_op: begin
                exc_d  = 1'b1;
                code_d = EXC_INV;
            end
            valid_op && ovf_exc: begin
                exc_d  = 1'b1;
                code_d = EXC_OVF;
            end
            valid_op && !ovf_exc && div0_exc: begin
                exc_d  = 1'b1;
                code_d = EXC_DIV0;
            end
            default: begin
                exc_d  = 1'b0;
                code_d = EXC_INV;
            end
        endcase
    end

    // Branch/jump resolution; a not-taken result always selects PC+4
    always_comb begin
        tgt_d   = SRC_PC4;
        taken_d = 1'b0;
        unique case (1'b1)
            op_q == OP_BEQ: begin
                tgt_d   = SRC_BR;
                taken_d = alu_zero;
            end
            op_q == OP_BNE: begin
                tgt_d   = SRC_BR;
                taken_d = !alu_zero;
            end
            op_q == OP_BLE: begin
                tgt_d   = SRC_BR;
                taken_d = !alu_gt;
            end
            op_q == OP_BGT: begin
                tgt_d   = SRC_BR;
                taken_d = alu_gt;
            end
            op_q == OP_J || op_q == OP_JAL: begin
                tgt_d   = SRC_J;
                taken_d = 1'b1;
            end
            op_q == OP_RTYPE && funct_q == FN_JR: begin
                tgt_d   = SRC_JR;
                taken_d = 1'b1;
            end
            default: begin
                tgt_d   = SRC_PC4;
                taken_d = 1'b0;
            end
        endcase
        sel_d = taken_d ? tgt_d : SRC_PC4;
    end

    // State register, instruction latch, wait counter and exception code
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            funct_q  <= '0;
            wait_cnt <= '0;
            exc_code <= EXC_INV;
        end else begin
            state <= next_state;
            if (state == S_IDLE && instr_valid) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
            if (state == S_EXC_WAIT && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state == S_RESOLVE && exc_d) begin
                exc_code <= code_d;
            end
        end
    end

    // Next-state sequencing
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:     next_state = instr_valid ? S_RESOLVE : S_IDLE;
            S_RESOLVE:  next_state = exc_d ? S_EXC_EPC : S_WRITE;
            S_WRITE:    next_state = S_DONE;
            S_EXC_EPC:  next_state = S_EXC_WAIT;
            S_EXC_WAIT: next_state = (wait_cnt == WAIT_LAST) ?
                                     S_EXC_LOAD : S_EXC_WAIT;
            S_EXC_LOAD: next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode for the state being entered, so outputs are registered
    always_comb begin
        src_d       = SRC_PC4;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        mem_read_d  = 1'b0;
        busy_d      = (next_state != S_IDLE);
        done_d      = 1'b0;
        unique case (next_state)
            S_WRITE: begin
                src_d      = sel_d;
                pc_write_d = taken_d;
            end
            S_EXC_EPC: begin
                epc_write_d = 1'b1;
            end
            S_EXC_WAIT: begin
                src_d      = SRC_VEC;
                mem_read_d = 1'b1;
            end
            S_EXC_LOAD: begin
                src_d      = SRC_VEC;
                pc_write_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                src_d = SRC_PC4;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_source <= SRC_PC4;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            mem_read  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pc_source <= src_d;
            pc_write  <= pc_write_d;
            epc_write <= epc_write_d;
            mem_read  <= mem_read_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// tb_pc_source_ctrl: scoreboard bench for pc_source_ctrl.
// Driver pushes expected transactions; monitor checks on done.
module tb_pc_source_ctrl;

    localparam int MW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       alu_gt = 1'b0;
    logic       ovf_exc = 1'b0;
    logic       div0_exc = 1'b0;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       mem_read;
    logic [1:0] exc_code;
    logic       busy;
    logic       done;

    pc_source_ctrl #(.MEM_WAIT(MW)) dut (
        .clk(clk),
        .reset(reset),
        .instr_valid(instr_valid),
        .opcode(opcode),
        .funct(funct),
        .alu_zero(alu_zero),
        .alu_gt(alu_gt),
        .ovf_exc(ovf_exc),
        .div0_exc(div0_exc),
        .pc_source(pc_source),
        .pc_write(pc_write),
        .epc_write(epc_write),
        .mem_read(mem_read),
        .exc_code(exc_code),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       exc;
        bit [2:0] sel;
        bit       taken;
        bit [1:0] code_after;
    } exp_t;

    exp_t     exp_q[$];
    int       checks = 0;
    int       errors = 0;
    bit [1:0] last_code = 2'b00;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, req, $time);
        end
    endtask

    // Reference: what an instruction should do, from the ISA rules
    function automatic exp_t model(input bit [5:0] op, input bit [5:0] fn,
                                   input bit z, input bit g,
                                   input bit o, input bit d,
                                   input bit [1:0] prev_code);
        exp_t m;
        bit legal;
        legal = op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h06, 6'h07, 6'h08, 6'h09, 6'h0F, 6'h20,
                           6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
        m.exc = 1'b1;
        m.sel = 3'd0;
        m.taken = 1'b0;
        if (!legal) m.code_after = 2'd0;
        else if (o) m.code_after = 2'd1;
        else if (d) m.code_after = 2'd2;
        else begin
            m.exc = 1'b0;
            m.code_after = prev_code;
            if (op == 6'h04 && z) m.sel = 3'd1;
            if (op == 6'h05 && !z) m.sel = 3'd1;
            if (op == 6'h06 && !g) m.sel = 3'd1;
            if (op == 6'h07 && g) m.sel = 3'd1;
            if (op == 6'h02 || op == 6'h03) m.sel = 3'd2;
            if (op == 6'h00 && fn == 6'h08) m.sel = 3'd3;
            m.taken = (m.sel != 3'd0);
        end
        return m;
    endfunction

    // Monitor: collects per-transaction activity, compares on done
    initial begin
        bit active = 0;
        int rel = 0;
        int pw_n, pw_rel, pw_src, ep_n, ep_rel, mr_n, mr_first, bad;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (active && exp_q.size() > 0) void'(exp_q.pop_front());
                active = 0;
            end else begin
                if (active) rel++;
                else if (busy) begin
                    active = 1;
                    rel = 1;
                    pw_n = 0; pw_rel = 0; pw_src = 0;
                    ep_n = 0; ep_rel = 0;
                    mr_n = 0; mr_first = 0; bad = 0;
                end
                if (!active) begin
                    if (pc_write || epc_write || mem_read || done ||
                        pc_source != 3'd0) begin
                        errors++;
                        $display("FAIL idle_out pw=%0d epc=%0d mr=%0d src=%0d",
                                 pc_write, epc_write, mem_read, pc_source);
                    end
                end else begin
                    if (!busy) bad++;
                    if (pc_write) begin
                        pw_n++; pw_rel = rel; pw_src = pc_source;
                    end
                    if (epc_write) begin
                        ep_n++; ep_rel = rel;
                    end
                    if (mem_read) begin
                        mr_n++;
                        if (mr_first == 0) mr_first = rel;
                        if (pc_source != 3'd4) bad++;
                    end
                    if (pc_source != 3'd0 && !pc_write && !mem_read) bad++;
                    if (done || rel > 40) begin
                        active = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("done_lat", rel, e.exc ? 4 + MW : 3);
                            chk("pc_write_n", pw_n, (e.exc || e.taken) ? 1 : 0);
                            if (pw_n > 0) begin
                                chk("pc_write_lat", pw_rel, e.exc ? 3 + MW : 2);
                                chk("pc_source", pw_src, e.exc ? 4 : e.sel);
                            end
                            chk("epc_write_n", ep_n, e.exc ? 1 : 0);
                            if (ep_n > 0) chk("epc_write_lat", ep_rel, 2);
                            chk("mem_read_n", mr_n, e.exc ? MW : 0);
                            if (mr_n > 0) chk("mem_read_start", mr_first, 3);
                            chk("exc_code", exc_code, e.code_after);
                            chk("src_busy_rules", bad, 0);
                        end
                    end
                end
            end
        end
    end

    // Issue one instruction; noise 0: quiet, 1: random, 2: always pulse
    task automatic issue(input bit [5:0] op, input bit [5:0] fn,
                         input bit z, input bit g, input bit o, input bit d,
                         input int noise);
        exp_t m;
        int n;
        @(posedge clk);
        #2;
        instr_valid = 1'b1;
        opcode = op;
        funct = fn;
        {alu_zero, alu_gt, ovf_exc, div0_exc} = 4'($urandom);
        m = model(op, fn, z, g, o, d, last_code);
        last_code = m.code_after;
        exp_q.push_back(m);
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
        opcode = 6'($urandom);
        funct = 6'($urandom);
        {alu_zero, alu_gt, ovf_exc, div0_exc} = {z, g, o, d};
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            {alu_zero, alu_gt, ovf_exc, div0_exc} = 4'($urandom);
            opcode = 6'($urandom);
            instr_valid = (noise == 2) ? 1'b1 :
                          (noise == 1) ? 1'($urandom) : 1'b0;
            if (done) break;
            n++;
            if (n > 40) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
    endtask

    initial begin
        bit [5:0] vops[17] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h06, 6'h07, 6'h08, 6'h09, 6'h0F, 6'h20,
                               6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
        int pw_seen;
        bit [5:0] op;
        bit [5:0] fn;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_source", pc_source, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_exc_code", exc_code, 0);
        chk("rst_done", done, 0);
        #1;
        reset = 1'b1;

        issue(6'h04, 6'h00, 1, 0, 0, 0, 0);
        issue(6'h05, 6'h00, 1, 0, 0, 0, 0);
        issue(6'h00, 6'h08, 0, 0, 0, 0, 0);
        issue(6'h00, 6'h20, 0, 0, 0, 0, 0);
        issue(6'h3F, 6'h00, 0, 0, 1, 0, 0);
        issue(6'h20, 6'h00, 0, 0, 1, 1, 0);
        issue(6'h21, 6'h00, 0, 0, 0, 1, 0);
        issue(6'h23, 6'h00, 0, 0, 0, 0, 0);
        issue(6'h06, 6'h00, 0, 1, 0, 0, 0);
        issue(6'h07, 6'h00, 0, 1, 0, 0, 0);
        issue(6'h03, 6'h00, 0, 0, 0, 0, 0);
        issue(6'h04, 6'h00, 1, 0, 0, 0, 2);

        // Reset in the middle of the vector wait
        @(posedge clk);
        #2;
        instr_valid = 1'b1;
        opcode = 6'h3F;
        exp_q.push_back(model(6'h3F, 6'h00, 0, 0, 0, 0, last_code));
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_mem_read", mem_read, 1);
        reset = 1'b0;
        last_code = 2'b00;
        #1;
        chk("mid_rst_mem_read", mem_read, 0);
        chk("mid_rst_pc_source", pc_source, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_epc_write", epc_write, 0);
        chk("mid_rst_exc_code", exc_code, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        pw_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (pc_write || epc_write) pw_seen++;
        end
        chk("post_rst_writes", pw_seen, 0);
        chk("post_rst_queue", exp_q.size(), 0);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) < 8) ?
                 vops[$urandom_range(0, 16)] : 6'($urandom);
            fn = $urandom_range(0, 1) ? 6'h08 : 6'($urandom);
            issue(op, fn, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
